// File: rtl/nx_rbus_master_if.sv
// Host-side request/response handshake bundle for nx_rbus_master.
// master: host drives requests and rsp_ready; slave: the bus master block.
interface nx_rbus_master_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );
endinterface

// File: rtl/nx_rbus_master.sv
// RBUS ring master: issues one read/write strobe per host request, waits
// for ack/err_ack from the ring or a programmable timeout, and returns a
// response. Ports: clk, rst_n, host (req/rsp handshake, slave modport),
// cfg_timeout, rbus_* ring feed/return, stat_timeout_cnt, stat_stray_ack.
module nx_rbus_master #(
    parameter int N_RBUS_ADDR_BITS = 16,
    parameter int N_RBUS_DATA_BITS = 32,
    parameter logic [N_RBUS_DATA_BITS-1:0] TIMEOUT_DATA = 32'hDEAD_C0DE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    nx_rbus_master_if.slave             host,
    input  logic [15:0]                 cfg_timeout,
    output logic [N_RBUS_ADDR_BITS-1:0] rbus_addr_o,
    output logic                        rbus_wr_strb_o,
    output logic [N_RBUS_DATA_BITS-1:0] rbus_wr_data_o,
    output logic                        rbus_rd_strb_o,
    input  logic [N_RBUS_DATA_BITS-1:0] rbus_rd_data_i,
    input  logic                        rbus_ack_i,
    input  logic                        rbus_err_ack_i,
    output logic [15:0]                 stat_timeout_cnt,
    output logic                        stat_stray_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                      state_q;
    logic [15:0]                 timer_q;
    logic [15:0]                 timer_d;
    logic [15:0]                 tcnt_q;
    logic [15:0]                 tcnt_d;
    logic                        wr_q;
    logic                        req_ready_q;
    logic [N_RBUS_ADDR_BITS-1:0] addr_q;
    logic [N_RBUS_DATA_BITS-1:0] wdata_q;
    logic                        wr_strb_q;
    logic                        rd_strb_q;
    logic                        rsp_valid_q;
    logic [N_RBUS_DATA_BITS-1:0] rsp_rdata_q;
    logic                        rsp_err_q;
    logic                        rsp_timeout_q;
    logic                        stray_q;
    logic                        ack_any;
    logic                        expire;

    assign ack_any = rbus_ack_i | rbus_err_ack_i;

    // Expiry only counts when no ack is present, so an ack in the
    // same cycle always wins.
    assign expire = (cfg_timeout != 16'd0) && (timer_q == cfg_timeout);

    always_comb begin
        timer_d = timer_q;
        if (timer_q != 16'hFFFF) begin
            timer_d = timer_q + 16'd1;
        end
        tcnt_d = tcnt_q;
        if (tcnt_q != 16'hFFFF) begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            tcnt_q        <= '0;
            wr_q          <= 1'b0;
            req_ready_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_strb_q     <= 1'b0;
            rd_strb_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            stray_q       <= 1'b0;
        end else begin
            // Any ack outside WAIT has no transaction to belong to.
            stray_q <= ack_any && (state_q != WAIT);
            unique case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (host.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        wr_q        <= host.req_wr;
                        addr_q      <= host.req_addr;
                        wdata_q     <= host.req_wdata;
                        wr_strb_q   <= host.req_wr;
                        rd_strb_q   <= !host.req_wr;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wr_strb_q <= 1'b0;
                    rd_strb_q <= 1'b0;
                    timer_q   <= '0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    timer_q <= timer_d;
                    if (ack_any) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= wr_q ? '0 : rbus_rd_data_i;
                        rsp_err_q     <= rbus_err_ack_i;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RESP;
                    end else if (expire) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= wr_q ? '0 : TIMEOUT_DATA;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        tcnt_q        <= tcnt_d;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    // No accept here: req_ready only rises once in IDLE.
                    if (host.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign host.req_ready   = req_ready_q;
    assign host.rsp_valid   = rsp_valid_q;
    assign host.rsp_rdata   = rsp_rdata_q;
    assign host.rsp_err     = rsp_err_q;
    assign host.rsp_timeout = rsp_timeout_q;

    assign rbus_addr_o      = addr_q;
    assign rbus_wr_data_o   = wdata_q;
    assign rbus_wr_strb_o   = wr_strb_q;
    assign rbus_rd_strb_o   = rd_strb_q;
    assign stat_timeout_cnt = tcnt_q;
    assign stat_stray_ack   = stray_q;

endmodule

// File: tb/tb_nx_rbus_master.sv
// Directed bench for nx_rbus_master: write/read, backpressure, timeout,
// ack-vs-expiry, err_ack, stray acks and mid-transaction reset.
module tb_nx_rbus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_timeout;
    logic [15:0] rbus_addr_o;
    logic        rbus_wr_strb_o;
    logic [31:0] rbus_wr_data_o;
    logic        rbus_rd_strb_o;
    logic [31:0] rbus_rd_data_i;
    logic        rbus_ack_i;
    logic        rbus_err_ack_i;
    logic [15:0] stat_timeout_cnt;
    logic        stat_stray_ack;

    int tests = 0;
    int fails = 0;
    int n_wr = 0;
    int n_rd = 0;

    nx_rbus_master_if #(.AW(16), .DW(32)) bus ();

    nx_rbus_master dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .host             (bus.slave),
        .cfg_timeout      (cfg_timeout),
        .rbus_addr_o      (rbus_addr_o),
        .rbus_wr_strb_o   (rbus_wr_strb_o),
        .rbus_wr_data_o   (rbus_wr_data_o),
        .rbus_rd_strb_o   (rbus_rd_strb_o),
        .rbus_rd_data_i   (rbus_rd_data_i),
        .rbus_ack_i       (rbus_ack_i),
        .rbus_err_ack_i   (rbus_err_ack_i),
        .stat_timeout_cnt (stat_timeout_cnt),
        .stat_stray_ack   (stat_stray_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rbus_wr_strb_o) n_wr++;
        if (rbus_rd_strb_o) n_rd++;
    end

    task automatic step(int k = 1);
        repeat (k) @(negedge clk);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Presents a request at an IDLE negedge; returns in the strobe cycle.
    task automatic issue(bit wr, logic [15:0] a, logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(int max, output int n);
        n = 0;
        while (!bus.rsp_valid && n < max) begin
            step();
            n++;
        end
        chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("rsp_done", 32'(bus.rsp_valid), 32'd0);
        chk("rdy_back", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int n;
        int b_wr;
        int b_rd;
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        cfg_timeout    = '0;
        rbus_rd_data_i = '0;
        rbus_ack_i     = 1'b0;
        rbus_err_ack_i = 1'b0;

        step(2);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_wstb", 32'(rbus_wr_strb_o), 32'd0);
        chk("rst_rstb", 32'(rbus_rd_strb_o), 32'd0);
        chk("rst_tcnt", 32'(stat_timeout_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_up", 32'(bus.req_ready), 32'd1);

        // Write, ack 3 cycles after the strobe
        b_wr = n_wr;
        b_rd = n_rd;
        issue(1'b1, 16'h0123, 32'hA5A5_5A5A);
        chk("w_strb", 32'(rbus_wr_strb_o), 32'd1);
        chk("w_rstb", 32'(rbus_rd_strb_o), 32'd0);
        chk("w_addr", 32'(rbus_addr_o), 32'h0123);
        chk("w_data", rbus_wr_data_o, 32'hA5A5_5A5A);
        chk("w_rdy", 32'(bus.req_ready), 32'd0);
        step(3);
        rbus_ack_i = 1'b1;
        step();
        rbus_ack_i = 1'b0;
        chk("w_valid", 32'(bus.rsp_valid), 32'd1);
        chk("w_err", 32'(bus.rsp_err), 32'd0);
        chk("w_to", 32'(bus.rsp_timeout), 32'd0);
        chk("w_rdata", bus.rsp_rdata, 32'd0);
        chk("w_hold", 32'(rbus_addr_o), 32'h0123);
        finish_rsp();
        chk("w_nwr", 32'(n_wr - b_wr), 32'd1);
        chk("w_nrd", 32'(n_rd - b_rd), 32'd0);

        // Read with 4 cycles of response backpressure
        b_rd = n_rd;
        issue(1'b0, 16'h0400, 32'h0);
        chk("r_strb", 32'(rbus_rd_strb_o), 32'd1);
        step();
        rbus_rd_data_i = 32'h1234_5678;
        rbus_ack_i = 1'b1;
        step();
        rbus_ack_i = 1'b0;
        rbus_rd_data_i = 32'h0;
        chk("r_valid", 32'(bus.rsp_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r_hold_v", 32'(bus.rsp_valid), 32'd1);
            chk("r_hold_d", bus.rsp_rdata, 32'h1234_5678);
            chk("r_hold_e", 32'(bus.rsp_err), 32'd0);
            chk("r_hold_rdy", 32'(bus.req_ready), 32'd0);
        end
        finish_rsp();
        chk("r_nrd", 32'(n_rd - b_rd), 32'd1);

        // Timeout after 10: timer runs 0..10 in WAIT, so rsp_valid
        // rises 11 edges after the strobe falls
        cfg_timeout = 16'd10;
        issue(1'b0, 16'h0800, 32'h0);
        wait_rsp(40, n);
        chk("to_lat", 32'(n - 1), 32'd11);
        chk("to_rdata", bus.rsp_rdata, 32'hDEAD_C0DE);
        chk("to_err", 32'(bus.rsp_err), 32'd1);
        chk("to_flag", 32'(bus.rsp_timeout), 32'd1);
        chk("to_cnt", 32'(stat_timeout_cnt), 32'd1);
        finish_rsp();

        // Ack in the expiry cycle (timer==5) wins
        cfg_timeout = 16'd5;
        issue(1'b0, 16'h0804, 32'h0);
        step(6);
        rbus_rd_data_i = 32'hCAFE_F00D;
        rbus_ack_i = 1'b1;
        step();
        rbus_ack_i = 1'b0;
        chk("aw_valid", 32'(bus.rsp_valid), 32'd1);
        chk("aw_to", 32'(bus.rsp_timeout), 32'd0);
        chk("aw_err", 32'(bus.rsp_err), 32'd0);
        chk("aw_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        chk("aw_cnt", 32'(stat_timeout_cnt), 32'd1);
        finish_rsp();

        // err_ack on a write
        cfg_timeout = 16'd0;
        issue(1'b1, 16'h0010, 32'h1111_1111);
        step(2);
        rbus_err_ack_i = 1'b1;
        step();
        rbus_err_ack_i = 1'b0;
        chk("e_valid", 32'(bus.rsp_valid), 32'd1);
        chk("e_err", 32'(bus.rsp_err), 32'd1);
        chk("e_to", 32'(bus.rsp_timeout), 32'd0);
        chk("e_rdata", bus.rsp_rdata, 32'd0);
        finish_rsp();

        // ack and err_ack together on a read
        issue(1'b0, 16'h0020, 32'h0);
        step();
        rbus_rd_data_i = 32'h55AA_55AA;
        rbus_ack_i = 1'b1;
        rbus_err_ack_i = 1'b1;
        step();
        rbus_ack_i = 1'b0;
        rbus_err_ack_i = 1'b0;
        chk("b_err", 32'(bus.rsp_err), 32'd1);
        chk("b_rdata", bus.rsp_rdata, 32'h55AA_55AA);
        finish_rsp();

        // Stray ack in IDLE
        rbus_ack_i = 1'b1;
        step();
        rbus_ack_i = 1'b0;
        chk("s_pulse", 32'(stat_stray_ack), 32'd1);
        chk("s_novalid", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("s_once", 32'(stat_stray_ack), 32'd0);
        chk("s_novalid2", 32'(bus.rsp_valid), 32'd0);

        // Ack after a timeout is stray
        cfg_timeout = 16'd3;
        issue(1'b0, 16'h0030, 32'h0);
        wait_rsp(20, n);
        chk("l_to", 32'(bus.rsp_timeout), 32'd1);
        rbus_rd_data_i = 32'h7777_7777;
        rbus_ack_i = 1'b1;
        step();
        rbus_ack_i = 1'b0;
        chk("l_stray", 32'(stat_stray_ack), 32'd1);
        chk("l_rdata", bus.rsp_rdata, 32'hDEAD_C0DE);
        chk("l_cnt", 32'(stat_timeout_cnt), 32'd2);
        finish_rsp();

        // Lowering cfg_timeout mid-WAIT applies to the next compare
        cfg_timeout = 16'd20;
        issue(1'b0, 16'h0034, 32'h0);
        step(3);
        cfg_timeout = 16'd2;
        step();
        chk("c_valid", 32'(bus.rsp_valid), 32'd1);
        chk("c_to", 32'(bus.rsp_timeout), 32'd1);
        finish_rsp();

        // Reset during WAIT aborts with no response
        cfg_timeout = 16'd0;
        issue(1'b0, 16'h0040, 32'h0);
        chk("x_strb", 32'(rbus_rd_strb_o), 32'd1);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        chk("x_rstb", 32'(rbus_rd_strb_o), 32'd0);
        chk("x_addr", 32'(rbus_addr_o), 32'd0);
        chk("x_rdy", 32'(bus.req_ready), 32'd0);
        chk("x_valid", 32'(bus.rsp_valid), 32'd0);
        chk("x_cnt", 32'(stat_timeout_cnt), 32'd0);
        chk("x_stray", 32'(stat_stray_ack), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("x_ready", 32'(bus.req_ready), 32'd1);
        issue(1'b0, 16'h0044, 32'h0);
        step();
        rbus_rd_data_i = 32'h0BAD_F00D;
        rbus_ack_i = 1'b1;
        step();
        rbus_ack_i = 1'b0;
        chk("x2_valid", 32'(bus.rsp_valid), 32'd1);
        chk("x2_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
        chk("x2_err", 32'(bus.rsp_err), 32'd0);
        finish_rsp();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nx_rbus_master.md
NX_RBUS_MASTER -- requirements
Module: nx_rbus_master

Interface
REQ-001 Parameter N_RBUS_ADDR_BITS, 16, RBUS address width.
REQ-002 Parameter N_RBUS_DATA_BITS, 32, RBUS data width.
REQ-003 Parameter TIMEOUT_DATA, 32'hDEAD_C0DE, read data returned on timeout.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req_valid / req_ready  input / output  1 / 1  host request handshake.
REQ-007 req_wr  input  1  1 = write, 0 = read.
REQ-008 req_addr / req_wdata  input  16 / 32  host address and write data.
REQ-009 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-010 rsp_rdata, rsp_err, rsp_timeout  output  32, 1, 1  read data, error flag, timeout flag.
REQ-011 cfg_timeout  input  16  ack timeout in cycles; 0 disables the timeout.
REQ-012 rbus_addr_o, rbus_wr_strb_o, rbus_wr_data_o, rbus_rd_strb_o  output  16, 1, 32, 1  feed to the first ring node.
REQ-013 rbus_rd_data_i, rbus_ack_i, rbus_err_ack_i  input  32, 1, 1  returned from the last ring node.
REQ-014 stat_timeout_cnt  output  16  saturating count of timed-out transactions.
REQ-015 stat_stray_ack  output  1  one-cycle pulse on an unexpected ack or err_ack.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-017 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-018 In IDLE, req_valid&&req_ready SHALL latch req_wr, req_addr and req_wdata, and the FSM SHALL move to ISSUE.
REQ-019 ISSUE SHALL last one cycle: rbus_wr_strb_o=req_wr or rbus_rd_strb_o=!req_wr, driven high for exactly one cycle with rbus_addr_o and rbus_wr_data_o valid in the same cycle.
REQ-020 On leaving ISSUE, the wait timer SHALL be cleared to 0 and the FSM SHALL move to WAIT.
REQ-021 Strobe timing: request accepted at edge T, strobe high in cycle T+1.
REQ-022 rbus_addr_o and rbus_wr_data_o SHALL hold their last issued values until the next ISSUE.
REQ-023 In WAIT, the timer SHALL increment every cycle and saturate at 16'hFFFF.
REQ-024 In WAIT, rbus_ack_i||rbus_err_ack_i SHALL capture the response and move the FSM to RESP:
  - rsp_rdata = rbus_rd_data_i for a read, 0 for a write;
  - rsp_err = rbus_err_ack_i;
  - rsp_timeout = 0.
REQ-025 In WAIT, when cfg_timeout!=0 and timer==cfg_timeout with no ack in that cycle:
  - rsp_rdata = TIMEOUT_DATA for a read, 0 for a write;
  - rsp_err = 1, rsp_timeout = 1;
  - stat_timeout_cnt increments, saturating at 16'hFFFF;
  - the FSM moves to RESP.
REQ-026 If an ack and timeout expiry occur in the same cycle, the ack SHALL win.
REQ-027 If rbus_ack_i and rbus_err_ack_i are both high, the response SHALL have rsp_err=1.
REQ-028 rsp_valid SHALL be 1 throughout RESP, one cycle after the ack or timeout was sampled.
REQ-029 rsp_rdata, rsp_err and rsp_timeout SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-030 rsp_valid&&rsp_ready SHALL return the FSM to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-031 An ack or err_ack sampled in IDLE, ISSUE or RESP SHALL be ignored for data and SHALL pulse stat_stray_ack for one cycle.
REQ-032 An ack arriving after a timeout SHALL be treated as stray.
REQ-033 A change of cfg_timeout during WAIT SHALL take effect on the next cycle's compare.
REQ-034 With cfg_timeout=0, WAIT SHALL persist until an ack arrives.

Reset
REQ-035 While rst_n=0, the state SHALL be IDLE and the timer 0.
REQ-036 While rst_n=0, all rbus_* outputs, rsp_* outputs, stat_timeout_cnt and stat_stray_ack SHALL be 0, and req_ready SHALL be 0.
REQ-037 req_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-038 Reset asserted mid-transaction SHALL abort it with no response, and any strobe SHALL drop immediately.

Verification
REQ-039 Write addr 16'h0123, data 32'hA5A5_5A5A, ack 3 cycles after the strobe -> single wr strobe cycle with that addr/data; rsp_valid with err=0, timeout=0, rdata=0.
REQ-040 Read addr 16'h0400, ack with rd_data 32'h1234_5678, rsp_ready held 0 for 4 cycles -> rsp held stable, rdata=32'h1234_5678; req_ready=0 until the handshake completes.
REQ-041 Read with cfg_timeout=10 and no ack -> rsp_valid 11 cycles after the strobe; rdata=32'hDEAD_C0DE, err=1, timeout=1; stat_timeout_cnt=1.
REQ-042 Read with cfg_timeout=5 and ack in the expiry cycle -> normal response, timeout=0, stat_timeout_cnt unchanged.
REQ-043 err_ack on a write -> rsp_err=1; an ack injected in IDLE -> stat_stray_ack pulses once, no rsp_valid.
REQ-044 rst_n pulsed low during WAIT -> outputs 0 immediately; after release, a new read completes normally.
